// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: stage strobes, stalls, forwarding, memory freeze, drain/halt.
// Build option: define HAZARD_FWD_EN to enable EX operand forwarding; otherwise every RAW match stalls.
module pipe_hazard_ctrl (
   input  logic        CLK,
   input  logic        RST,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic [4:0]  ex_rd,
   input  logic        ex_regwrite,
   input  logic        ex_memread,
   input  logic [4:0]  mem_rd,
   input  logic        mem_regwrite,
   input  logic [4:0]  wb_rd,
   input  logic        wb_regwrite,
   input  logic        br_taken,
   input  logic        dmem_req,
   input  logic        dmem_ready,
   input  logic        halt_req,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idix_en,
   output logic        exmem_en,
   output logic        memwb_en,
   output logic        ifid_flush,
   output logic        idix_flush,
   output logic        exmem_flush,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
   output logic        halted,
   output logic [15:0] stall_cycles,
   output logic [1:0]  dbg_state
);

   // Handshake: dmem_req is held by MEM; the access completes on the cycle dmem_ready=1 with dmem_req=1.
   typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, DRAIN = 2'd2, HALTED = 2'd3} state_t;

   state_t     state, state_n;
   logic [1:0] drain_cnt, drain_cnt_n, drain_dec;

   logic m_ex_rs, m_ex_rt, m_mem_rs, m_mem_rt, m_wb_rs, m_wb_rt;
   logic load_use, wb_hz, stall_hz, mem_wait;

   assign m_ex_rs  = id_use_rs & (id_rs == ex_rd)  & ex_regwrite  & (ex_rd  != 5'd0);
   assign m_ex_rt  = id_use_rt & (id_rt == ex_rd)  & ex_regwrite  & (ex_rd  != 5'd0);
   assign m_mem_rs = id_use_rs & (id_rs == mem_rd) & mem_regwrite & (mem_rd != 5'd0);
   assign m_mem_rt = id_use_rt & (id_rt == mem_rd) & mem_regwrite & (mem_rd != 5'd0);
   assign m_wb_rs  = id_use_rs & (id_rs == wb_rd)  & wb_regwrite  & (wb_rd  != 5'd0);
   assign m_wb_rt  = id_use_rt & (id_rt == wb_rd)  & wb_regwrite  & (wb_rd  != 5'd0);

   assign load_use = (m_ex_rs | m_ex_rt) & ex_memread;
   // The regfile has no write-to-read bypass, so a WB producer always costs a bubble.
   assign wb_hz    = m_wb_rs | m_wb_rt;
   assign mem_wait = dmem_req & ~dmem_ready;

`ifdef HAZARD_FWD_EN
   logic [1:0] fwd_a_n, fwd_b_n, fwd_a_q, fwd_b_q;

   assign stall_hz = load_use | wb_hz;

   // EX holds the newer producer, so it wins over MEM.
   assign fwd_a_n = (m_ex_rs & ~ex_memread) ? 2'b01 : (m_mem_rs ? 2'b10 : 2'b00);
   assign fwd_b_n = (m_ex_rt & ~ex_memread) ? 2'b01 : (m_mem_rt ? 2'b10 : 2'b00);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         fwd_a_q <= 2'b00;
         fwd_b_q <= 2'b00;
      end else if (idix_en) begin
         fwd_a_q <= idix_flush ? 2'b00 : fwd_a_n;
         fwd_b_q <= idix_flush ? 2'b00 : fwd_b_n;
      end
   end

   assign fwd_a = fwd_a_q;
   assign fwd_b = fwd_b_q;
`else
   // Without forwarding the consumer waits in ID until the producer has retired.
   assign stall_hz = load_use | m_ex_rs | m_ex_rt | m_mem_rs | m_mem_rt | wb_hz;
   assign fwd_a    = 2'b00;
   assign fwd_b    = 2'b00;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= RUN;
         drain_cnt <= 2'd0;
      end else begin
         state     <= state_n;
         drain_cnt <= drain_cnt_n;
      end
   end

   assign drain_dec = (drain_cnt == 2'd0) ? 2'd0 : drain_cnt - 2'd1;

   always_comb begin
      state_n     = state;
      drain_cnt_n = drain_cnt;
      case (state)
         RUN, MEM_WAIT: begin
            if (mem_wait) begin
               state_n = MEM_WAIT;
            end else if (halt_req) begin
               state_n     = DRAIN;
               drain_cnt_n = 2'd3;
            end else begin
               state_n = RUN;
            end
         end
         DRAIN: begin
            // The counter only moves on cycles where the pipeline actually advances.
            if (!mem_wait) begin
               drain_cnt_n = drain_dec;
               if (drain_dec == 2'd0) state_n = HALTED;
            end
         end
         HALTED: begin
            if (!halt_req) state_n = RUN;
         end
         default: state_n = RUN;
      endcase
   end

   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idix_en     = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      ifid_flush  = 1'b0;
      idix_flush  = 1'b0;
      exmem_flush = 1'b0;
      if (RST) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idix_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_en    = 1'b0;
         ifid_flush  = 1'b1;
         idix_flush  = 1'b1;
         exmem_flush = 1'b1;
      end else if (mem_wait || state == HALTED) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idix_en  = 1'b0;
         exmem_en = 1'b0;
         memwb_en = 1'b0;
      end else if (br_taken) begin
         // While draining the target is deliberately dropped.
         pc_en       = (state != DRAIN);
         ifid_flush  = 1'b1;
         idix_flush  = 1'b1;
         exmem_flush = 1'b1;
      end else if (state == DRAIN) begin
         pc_en      = 1'b0;
         ifid_flush = 1'b1;
      end else if (stall_hz) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idix_flush = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stall_cycles <= 16'd0;
      end else if (!pc_en && stall_cycles != 16'hFFFF) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end

   assign halted    = (state == HALTED);
   assign dbg_state = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expectations follow the HAZARD_FWD_EN build setting.
module tb_pipe_hazard_ctrl;

   logic        CLK, RST;
   logic [4:0]  id_rs, id_rt, ex_rd, mem_rd, wb_rd;
   logic        id_use_rs, id_use_rt, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
   logic        br_taken, dmem_req, dmem_ready, halt_req;
   logic        pc_en, ifid_en, idix_en, exmem_en, memwb_en;
   logic        ifid_flush, idix_flush, exmem_flush, halted;
   logic [1:0]  fwd_a, fwd_b, dbg_state;
   logic [15:0] stall_cycles;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [1:0] S_RUN = 2'd0, S_MEM_WAIT = 2'd1, S_DRAIN = 2'd2, S_HALTED = 2'd3;

   pipe_hazard_ctrl dut (
      .CLK(CLK), .RST(RST),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
      .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req),
      .pc_en(pc_en), .ifid_en(ifid_en), .idix_en(idix_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
      .ifid_flush(ifid_flush), .idix_flush(idix_flush), .exmem_flush(exmem_flush),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .stall_cycles(stall_cycles),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // checking
   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   function automatic logic [4:0] ens();
      return {pc_en, ifid_en, idix_en, exmem_en, memwb_en};
   endfunction

   function automatic logic [2:0] fls();
      return {ifid_flush, idix_flush, exmem_flush};
   endfunction

   // drivers
   task automatic clear_inputs();
      id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
      ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
      mem_rd = 5'd0; mem_regwrite = 1'b0;
      wb_rd = 5'd0; wb_regwrite = 1'b0;
      br_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1; halt_req = 1'b0;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      clear_inputs();
      tick();
      RST = 1'b0;
      #1;
   endtask

   initial begin
      RST = 1'b0;
      clear_inputs();
      #1 RST = 1'b1;
      #1;
      // reset values
      check("rst_en", ens(), 5'b00000);
      check("rst_flush", fls(), 3'b111);
      check("rst_fwd", {fwd_a, fwd_b}, 4'b0000);
      check("rst_stall", stall_cycles, 16'd0);
      check("rst_halted", halted, 1'b0);
      check("rst_state", dbg_state, S_RUN);
      tick();
      check("rst_hold_en", ens(), 5'b00000);
      RST = 1'b0;
      #1;
      check("run_en", ens(), 5'b11111);
      check("run_flush", fls(), 3'b000);

      // forward from EX
      do_reset();
      ex_rd = 5'd3; ex_regwrite = 1'b1; id_rs = 5'd3; id_use_rs = 1'b1;
      #1;
`ifdef HAZARD_FWD_EN
      check("fex_pc_en", pc_en, 1'b1);
      tick();
      clear_inputs();
      check("fex_fwd_a", fwd_a, 2'b01);
      check("fex_stall", stall_cycles, 16'd0);
`else
      check("fex_pc_en0", pc_en, 1'b0);
      tick();
      ex_regwrite = 1'b0; mem_rd = 5'd3; mem_regwrite = 1'b1;
      #1;
      check("fex_pc_en1", pc_en, 1'b0);
      tick();
      mem_regwrite = 1'b0; wb_rd = 5'd3; wb_regwrite = 1'b1;
      #1;
      check("fex_pc_en2", pc_en, 1'b0);
      tick();
      wb_regwrite = 1'b0;
      #1;
      check("fex_pc_en3", pc_en, 1'b1);
      check("fex_stall", stall_cycles, 16'd3);
      check("fex_fwd_a", fwd_a, 2'b00);
`endif

      // EX and MEM producers for different operands
      do_reset();
      ex_rd = 5'd4; ex_regwrite = 1'b1; mem_rd = 5'd6; mem_regwrite = 1'b1;
      id_rs = 5'd4; id_use_rs = 1'b1; id_rt = 5'd6; id_use_rt = 1'b1;
      #1;
`ifdef HAZARD_FWD_EN
      check("fmix_pc_en", pc_en, 1'b1);
      tick();
      check("fmix_fwd", {fwd_a, fwd_b}, 4'b0110);
      // both EX and MEM write $4: EX wins
      ex_rd = 5'd4; mem_rd = 5'd4; id_rt = 5'd0;
      #1;
      tick();
      check("fprio_fwd", {fwd_a, fwd_b}, 4'b0100);
`else
      check("fmix_pc_en", pc_en, 1'b0);
      check("fmix_flush", fls(), 3'b010);
`endif

      // load-use
      do_reset();
      ex_rd = 5'd5; ex_regwrite = 1'b1; ex_memread = 1'b1; id_rs = 5'd5; id_use_rs = 1'b1;
      #1;
      check("lu_en", ens(), 5'b00111);
      check("lu_flush", fls(), 3'b010);
      tick();
      ex_regwrite = 1'b0; ex_memread = 1'b0; mem_rd = 5'd5; mem_regwrite = 1'b1;
      #1;
`ifdef HAZARD_FWD_EN
      check("lu_pc_en", pc_en, 1'b1);
      tick();
      check("lu_fwd_a", fwd_a, 2'b10);
      check("lu_stall", stall_cycles, 16'd1);
`else
      check("lu_pc_en1", pc_en, 1'b0);
      tick();
      mem_regwrite = 1'b0; wb_rd = 5'd5; wb_regwrite = 1'b1;
      #1;
      check("lu_pc_en2", pc_en, 1'b0);
      tick();
      wb_regwrite = 1'b0;
      #1;
      check("lu_pc_en3", pc_en, 1'b1);
      check("lu_stall", stall_cycles, 16'd3);
`endif

      // WB match
      do_reset();
      wb_rd = 5'd7; wb_regwrite = 1'b1; id_rt = 5'd7; id_use_rt = 1'b1;
      #1;
      check("wb_en", ens(), 5'b00111);
      tick();
      clear_inputs();
      #1;
      check("wb_pc_en", pc_en, 1'b1);
      check("wb_stall", stall_cycles, 16'd1);

      // branch during load-use stall
      do_reset();
      ex_rd = 5'd5; ex_regwrite = 1'b1; ex_memread = 1'b1; id_rs = 5'd5; id_use_rs = 1'b1;
      br_taken = 1'b1;
      #1;
      check("br_en", ens(), 5'b11111);
      check("br_flush", fls(), 3'b111);
      tick();
      clear_inputs();
      check("br_stall", stall_cycles, 16'd0);
      check("br_fwd_a", fwd_a, 2'b00);

      // memory wait
      do_reset();
      dmem_req = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("mw_en", ens(), 5'b00000);
         check("mw_flush", fls(), 3'b000);
         tick();
         check("mw_state", dbg_state, S_MEM_WAIT);
      end
      dmem_ready = 1'b1;
      #1;
      check("mw_ready_en", ens(), 5'b11111);
      check("mw_stall", stall_cycles, 16'd4);
      tick();
      dmem_req = 1'b0;
      check("mw_state_run", dbg_state, S_RUN);

      // drain and resume
      do_reset();
      halt_req = 1'b1;
      #1;
      check("dr_run_pc", pc_en, 1'b1);
      tick();
      for (int i = 0; i < 3; i++) begin
         check("dr_state", dbg_state, S_DRAIN);
         check("dr_en", ens(), 5'b01111);
         check("dr_flush", fls(), 3'b100);
         tick();
      end
      check("dr_halted", halted, 1'b1);
      check("dr_halt_en", ens(), 5'b00000);
      tick();
      check("dr_halted2", halted, 1'b1);
      halt_req = 1'b0;
      #1;
      check("dr_halted3", halted, 1'b1);
      tick();
      check("dr_resume_halted", halted, 1'b0);
      check("dr_resume_pc", pc_en, 1'b1);
      check("dr_resume_state", dbg_state, S_RUN);
      check("dr_stall", stall_cycles, 16'd5);

      // register 0
      do_reset();
      ex_rd = 5'd0; ex_regwrite = 1'b1; ex_memread = 1'b1;
      mem_rd = 5'd0; mem_regwrite = 1'b1; wb_rd = 5'd0; wb_regwrite = 1'b1;
      id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b1; id_use_rt = 1'b1;
      #1;
      check("r0_en", ens(), 5'b11111);
      tick();
      check("r0_fwd", {fwd_a, fwd_b}, 4'b0000);
      check("r0_stall", stall_cycles, 16'd0);

      // async reset in the middle of a memory wait
      do_reset();
      dmem_req = 1'b1; dmem_ready = 1'b0;
      tick();
      tick();
      check("ar_state_mw", dbg_state, S_MEM_WAIT);
      check("ar_stall_pre", stall_cycles, 16'd2);
      #2 RST = 1'b1;
      #1;
      check("ar_en", ens(), 5'b00000);
      check("ar_flush", fls(), 3'b111);
      check("ar_state", dbg_state, S_RUN);
      check("ar_stall", stall_cycles, 16'd0);
      clear_inputs();
      #1 RST = 1'b0;
      #1;
      check("ar_rel_en", ens(), 5'b11111);
      tick();
      check("ar_rel_state", dbg_state, S_RUN);
      check("ar_rel_stall", stall_cycles, 16'd0);

      // report
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
